// File: rtl/uart_pkg.sv
// Shared types and baud-derived defaults for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states
//   CLK_HZ, BAUD, BIT_CYCLES : default clock/baud constants
package uart_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD       = 115200;
  localparam int unsigned BIT_CYCLES = 434;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first requester set, searching upward
// from last_grant+1 and wrapping.
//   req        : request vector
//   last_grant : index granted most recently
//   pick       : next index to grant (last_grant when nothing requests)
//   any        : at least one request is set
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] pick,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest set request wins.
  always_comb begin
    pick = last_grant;
    cand = '0;
    any  = |req;
    for (int unsigned i = N; i >= 1; i--) begin
      cand = IW'((32'(last_grant) + i) % N);
      if (req[cand]) pick = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-serial UART transmitter
// among NUM_REQ requesters, with a forced idle gap after each packet and a
// stall timeout that releases a requester idling mid-packet.
//   clock50, reset_n            : clock, async active-low reset
//   req_valid/req_data/req_last : per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                   : per-requester byte accepted this cycle
//   tx_valid/tx_data/tx_ready   : byte interface to the serializer
//   grant_id                    : current/last granted requester
//   grant_active                : a packet is in progress
//   timeout_pulse               : one-cycle pulse on forced release
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = BIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clock50,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout_pulse
);

  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  // A zero-length gap still spends one cycle in GAP.
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             pulse_q, pulse_d;
  logic             active_q;
  logic [IDW-1:0]   pick;
  logic             any_req;
  logic             g_valid;
  logic             g_last;

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_rr_pick (
    .req        (req_valid),
    .last_grant (grant_q),
    .pick       (pick),
    .any        (any_req)
  );

  assign g_valid       = req_valid[grant_q];
  assign g_last        = req_last[grant_q];
  assign grant_id      = grant_q;
  assign grant_active  = active_q;
  assign timeout_pulse = pulse_q;

  // State and counter registers.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= IDW'(NUM_REQ - 1);
      gap_q    <= '0;
      tmo_q    <= '0;
      pulse_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      pulse_q  <= pulse_d;
      active_q <= (state_d == LOCK);
    end
  end

  // Next-state logic; the byte path is a pass-through from the granted requester.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    pulse_d   = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          tmo_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        tx_valid           = g_valid;
        tx_data            = req_data[{grant_q, 3'b000} +: 8];
        req_ready[grant_q] = tx_ready & g_valid;
        if (g_valid && tx_ready) begin
          tmo_d = '0;
          if (g_last) begin
            gap_d   = '0;
            state_d = GAP;
          end
        end else if (!g_valid) begin
          // Only cycles with the requester silent count toward the stall limit.
          if (tmo_q >= CNT_W'(TMO_LAST)) begin
            tmo_d   = '0;
            gap_d   = '0;
            pulse_d = 1'b1;
            state_d = GAP;
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q >= CNT_W'(GAP_LAST)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester models stream queued bytes,
// expected (id, byte) pairs are queued by hand and checked by a monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 434;
  localparam int unsigned TMO  = 16;

  logic              clock50 = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [1:0]        grant_id;
  logic              grant_active;
  logic              timeout_pulse;

  always #10 clock50 = ~clock50;

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock50       (clock50),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .grant_active  (grant_active),
    .timeout_pulse (timeout_pulse)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Requester models: per-requester byte FIFO {last, data}.
  logic [8:0]      mem [NREQ][32];
  int              rd  [NREQ];
  int              wr  [NREQ];
  logic [NREQ-1:0] fire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = (rd[i] != wr[i]);
      req_data[8*i +: 8]  = mem[i][rd[i] % 32][7:0];
      req_last[i]         = mem[i][rd[i] % 32][8];
    end
  end

  always @(negedge clock50) fire = req_ready;

  always @(posedge clock50) begin
    #1;
    for (int i = 0; i < NREQ; i++) if (fire[i]) rd[i] = rd[i] + 1;
  end

  task automatic push(input int id, input logic [7:0] data, input logic last);
    mem[id][wr[id] % 32] = {last, data};
    wr[id] = wr[id] + 1;
  endtask

  // Scoreboard: expected {id, byte} in transfer order.
  logic [9:0] exp_q[$];
  int         cyc = 0;
  int         last_cyc = 0;
  bit         prev_last = 1'b0;
  int         xfer_cnt [NREQ];
  int         pulses = 0;

  task automatic expect_byte(input int id, input logic [7:0] data);
    exp_q.push_back({2'(id), data});
  endtask

  always @(posedge clock50) cyc <= cyc + 1;

  always @(negedge clock50) begin
    logic [9:0]      e;
    logic [NREQ-1:0] exp_rdy;
    if (!reset_n) begin
      prev_last = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {grant_id, tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("xfer", {grant_active, grant_id, tx_data}, {1'b1, e});
          exp_rdy = '0;
          exp_rdy[e[9:8]] = 1'b1;
          check("ready_onehot", req_ready, exp_rdy);
          if (prev_last) check("inter_packet_gap", (cyc - last_cyc >= int'(GAP) + 2), 1);
          prev_last = req_last[e[9:8]];
          last_cyc  = cyc;
          xfer_cnt[e[9:8]]++;
        end
      end else begin
        check("ready_no_xfer", req_ready, 0);
        if (!grant_active) check("idle_outputs", {tx_valid, tx_data}, 0);
      end
      if (timeout_pulse) pulses++;
    end
  end

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(posedge clock50);
      k++;
    end
    check("drain", exp_q.size(), 0);
    repeat (GAP + 8) @(posedge clock50);
    #1;
  endtask

  initial begin
    int k;
    int g;
    int base;
    int p0;
    bit seen;
    reset_n  = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = 0;
      wr[i] = 0;
      xfer_cnt[i] = 0;
      for (int j = 0; j < 32; j++) mem[i][j] = '0;
    end

    // Reset values.
    repeat (2) @(posedge clock50);
    @(negedge clock50);
    check("rst_grant_id", grant_id, 3);
    check("rst_grant_active", grant_active, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    @(posedge clock50); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock50);
    #1;

    // Contention: 0,1,2 together, then 0 and 3 together.
    tx_ready = 1'b1;
    push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1);
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
    drain();
    push(0, 8'h30, 1'b1); push(3, 8'h33, 1'b1);
    expect_byte(3, 8'h33); expect_byte(0, 8'h30);
    drain();

    // Single requester: 3-byte packet, then a second packet to time the gap.
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1); push(0, 8'h44, 1'b1);
    expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43); expect_byte(0, 8'h44);
    @(negedge clock50);
    check("single_pre_grant", grant_active, 0);
    @(negedge clock50);
    check("single_grant", {grant_active, grant_id}, {1'b1, 2'd0});
    for (k = 1; k <= 10; k++) begin
      @(negedge clock50);
      if (req_ready[0] && req_last[0]) break;
    end
    check("one_byte_per_cycle", k, 2);
    g = 0;
    seen = 1'b0;
    while (g < 1000) begin
      @(negedge clock50);
      if (grant_active) break;
      if (tx_valid) seen = 1'b1;
      g++;
    end
    check("gap_plus_idle_len", g, GAP + 1);
    check("gap_quiet", seen, 0);
    drain();

    // Backpressure: tx_ready toggles during a 4-byte packet.
    base = xfer_cnt[2];
    p0   = pulses;
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    expect_byte(2, 8'hA0); expect_byte(2, 8'hA1); expect_byte(2, 8'hA2); expect_byte(2, 8'hA3);
    for (int c = 0; c < 14; c++) begin
      tx_ready = (c % 2 == 1);
      @(posedge clock50); #1;
    end
    tx_ready = 1'b1;
    drain();
    check("bp_xfer_count", xfer_cnt[2] - base, 4);
    check("bp_no_timeout", pulses - p0, 0);

    // Stall timeout: req 1 sends one non-last byte and goes quiet; req 2 waits.
    p0 = pulses;
    push(1, 8'h55, 1'b0); push(2, 8'h66, 1'b1);
    expect_byte(1, 8'h55); expect_byte(2, 8'h66);
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock50);
      if (req_ready[1]) begin seen = 1'b1; break; end
    end
    check("tmo_first_xfer", seen, 1);
    @(posedge clock50);
    for (k = 1; k <= 40; k++) begin
      @(posedge clock50); #1;
      if (timeout_pulse) break;
    end
    check("tmo_delay", k, TMO);
    check("tmo_released", grant_active, 0);
    @(posedge clock50); #1;
    check("tmo_one_cycle", timeout_pulse, 0);
    drain();
    check("tmo_pulse_count", pulses - p0, 1);

    // Lock isolation: req 1 waits while req 0 finishes its packet.
    tx_ready = 1'b0;
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1); push(1, 8'hD1, 1'b1);
    expect_byte(0, 8'hC0); expect_byte(0, 8'hC1); expect_byte(0, 8'hC2); expect_byte(1, 8'hD1);
    seen = 1'b0;
    for (k = 0; k < 60; k++) begin
      @(posedge clock50); #1;
      tx_ready = (k >= 4);
      @(negedge clock50);
      if (grant_active) check("lock_isolation", {req_ready[1], (tx_data == 8'hD1)}, 0);
      if (req_ready[0] && req_last[0]) begin seen = 1'b1; break; end
    end
    check("iso_done", seen, 1);
    drain();

    // Reset during the second byte of a packet.
    tx_ready = 1'b1;
    push(0, 8'hE0, 1'b0); push(0, 8'hE1, 1'b0); push(0, 8'hE2, 1'b1); push(1, 8'hF1, 1'b1);
    expect_byte(0, 8'hE0); expect_byte(0, 8'hE1); expect_byte(0, 8'hE2); expect_byte(1, 8'hF1);
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock50);
      if (req_ready[0]) begin seen = 1'b1; break; end
    end
    check("mid_first_xfer", seen, 1);
    @(posedge clock50); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {grant_active, grant_id, tx_valid, tx_data, req_ready, timeout_pulse},
          {1'b0, 2'd3, 1'b0, 8'h00, 4'h0, 1'b0});
    repeat (2) @(posedge clock50);
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock50);
      if (grant_active) begin seen = 1'b1; break; end
    end
    check("regrant_after_reset", {seen, grant_id}, {1'b1, 2'd0});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-serial UART transmitter among NUM_REQ requesters, e.g. a debug console, a status reporter and a VGA frame-stats dumper.
- Arbitration is packet-level round-robin. A granted requester keeps the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- An inter-packet idle gap is inserted between packets.
- Sits between client logic and the UART serializer, which uses a valid/ready byte interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 434, clock50 cycles of forced idle after each packet (434 ≈ one bit time at 115200 baud)
TIMEOUT_CYCLES, 65535, cycles a granted requester may hold req_valid low mid-packet before forced release (must be ≥1)

Ports:
clock50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  byte is last of packet
req_ready  output  NUM_REQ  per-requester byte accepted this cycle
tx_valid  output  1  byte valid to serializer
tx_data  output  8  byte to serializer
tx_ready  input  1  serializer accepts byte this cycle
grant_id  output  $clog2(NUM_REQ)  currently/last granted requester
grant_active  output  1  a packet is in progress (state LOCK)
timeout_pulse  output  1  one-cycle pulse on forced release

Behaviour:
- Interface: one clock (clock50); reset_n is asynchronous, active-low.
- Reset values:
  - state=IDLE.
  - grant_id=NUM_REQ-1, so requester 0 has first priority.
  - grant_active=0, timeout_pulse=0, gap and timeout counters=0.
  - req_ready=0, tx_valid=0, tx_data=0.
- Assertion of reset_n mid-packet aborts immediately. Any byte handshake in the same cycle is void.
- Transfer: a transfer occurs when tx_valid && tx_ready in LOCK.
- IDLE:
  - If any req_valid is high, select the first requester set in round-robin order starting at grant_id+1 (mod NUM_REQ).
  - Register grant_id. Next state LOCK.
  - Grant is registered, so grant_active rises 1 cycle after req_valid is seen.
  - No transfer happens in IDLE.
- LOCK:
  - Outputs are combinational from the granted requester g only: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready & req_valid[g]. All other req_ready bits are 0.
  - First byte can transfer in the first LOCK cycle.
  - On a transfer with req_last[g]=1: next state GAP.
  - Timeout counter:
    - Clears on every transfer and on entry to LOCK.
    - Increments on each LOCK cycle with req_valid[g]=0.
    - When it reaches TIMEOUT_CYCLES: assert timeout_pulse for 1 cycle and go to GAP.
    - Cycles spent waiting on tx_ready with req_valid high do NOT count.
- GAP:
  - tx_valid=0 and all req_ready=0. Count GAP_CYCLES cycles, then IDLE.
  - With GAP_CYCLES=0, GAP lasts exactly 1 cycle.
- Outside LOCK, tx_valid=0 and tx_data holds 0.
- Other requesters' req_valid is ignored while locked; their bytes stay pending and are never dropped.
- Round-robin wraps: after grant NUM_REQ-1, search starts at 0. A sole active requester is regranted after GAP.
- Counters are wide enough for max(GAP_CYCLES, TIMEOUT_CYCLES) and saturate, never wrap.

Decomposition:
- Package uart_pkg: state enum {IDLE, LOCK, GAP}; default baud-derived constants (CLK_HZ=50_000_000, BAUD=115200, BIT_CYCLES=434).
- Sub-module rr_pick: combinational round-robin priority select. Inputs: request vector and last grant. Outputs: next index and an any-request flag.

Test Plan:
- Single requester: req 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), tx_ready held 1.
  - grant_active is 1 one cycle after req_valid, with grant_id=0.
  - tx_data matches in order, one byte per cycle.
  - Then GAP lasts 434 cycles with tx_valid=0, then IDLE.
- Contention: reqs 0, 1, 2 assert together, each sends a 1-byte packet.
  - Grants are issued in order 0, 1, 2, each separated by a gap.
  - Then req 0 and req 3 assert together: grant goes to 3, then 0.
- Backpressure: tx_ready toggles 1/0 every cycle during a 4-byte packet.
  - Exactly 4 transfers occur, with no duplicates.
  - req_ready is high only when tx_ready is high.
  - No timeout occurs.
- Stall timeout: with TIMEOUT_CYCLES=16, req 1 sends 1 byte without last, then drops req_valid.
  - timeout_pulse fires exactly 16 cycles after the transfer.
  - State goes to GAP; req 2 pending is granted afterwards.
- Lock isolation: req 0 is mid-packet while req 1 holds valid throughout.
  - req_ready[1] stays 0 and tx_data never shows req 1's byte until req 0's last byte transfers.
- Reset mid-packet: drop reset_n for 2 cycles during the 2nd byte.
  - All outputs go to reset values asynchronously, and grant_id=NUM_REQ-1.
  - After release, req 0 is re-granted first.
